fc_layer_lanes: RTL and testbench

- Parametrised, multi-cycle fully connected layer: out[i] = sat(shift(bias[i] + Σ_j w[i][j]·in[j])).
- Computes LANES output neurons in parallel, one input element per clock, over OUT_SIZE/LANES groups.
- Uses the same flattened vector/matrix packing and start/done handshake as the existing FC layers.
- Adds:
  - async reset
  - busy flag
  - operand capture at start
  - fixed-point output shift
  - saturation
  - optional ReLU

---
 rtl/fc_layer_lanes.sv | 156 +++++++++++++++
 tb/tb_fc_layer_lanes.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_lanes.sv
// Multi-cycle fully connected layer: LANES neurons in parallel, one input element per clock.
// Optional ReLU on the stored results when FC_RELU_EN is defined.
module fc_layer_lanes #(
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 8,
    parameter int LANES      = 2,
    parameter int W          = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W*IN_SIZE-1:0]         in_vector_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat,
    input  logic [W*OUT_SIZE-1:0]        biases_flat,
    output logic [W*OUT_SIZE-1:0]        out_vector_flat,
    output logic                         busy,
    output logic                         done
);
    localparam int GROUPS = OUT_SIZE / LANES;
    localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int J_W    = $clog2(IN_SIZE);
    localparam logic [J_W-1:0] J_LAST = J_W'(IN_SIZE - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t                          state_reg;
    logic [G_W-1:0]                  g_reg;
    logic [J_W-1:0]                  j_reg;
    logic [W*IN_SIZE-1:0]            in_reg;
    logic [W*OUT_SIZE*IN_SIZE-1:0]   w_reg;
    logic [W*OUT_SIZE-1:0]           b_reg;
    logic [W*OUT_SIZE-1:0]           stage_reg;
    logic [W*OUT_SIZE-1:0]           stage_next;
    logic [W*OUT_SIZE-1:0]           out_reg;
    logic                            busy_reg;
    logic                            done_reg;
    logic [G_W-1:0]                  g_next;

    logic signed [ACC_WIDTH-1:0]     acc_reg   [LANES];
    logic signed [ACC_WIDTH-1:0]     prod_ext  [LANES];
    logic signed [ACC_WIDTH-1:0]     next_bias [LANES];
    logic [W-1:0]                    result    [LANES];

    // Wraps to 0 on the last group so the next-bias select never leaves the vector.
    assign g_next = (g_reg == G_LAST) ? '0 : g_reg + G_W'(1);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [W-1:0]         in_sel;
        logic signed [W-1:0]         w_sel;
        logic signed [W-1:0]         b_sel;
        logic signed [2*W-1:0]       prod;
        logic signed [ACC_WIDTH-1:0] shifted;
        logic signed [W-1:0]         clamped;

        assign in_sel  = in_reg[int'(j_reg) * W +: W];
        assign w_sel   = w_reg[((int'(g_reg) * LANES + gi) * IN_SIZE + int'(j_reg)) * W +: W];
        assign b_sel   = b_reg[(int'(g_next) * LANES + gi) * W +: W];
        assign prod    = (2*W)'(in_sel) * (2*W)'(w_sel);
        assign prod_ext[gi]  = ACC_WIDTH'(prod);
        assign next_bias[gi] = ACC_WIDTH'(b_sel);
        assign shifted = acc_reg[gi] >>> FRAC_SHIFT;

        always_comb begin
            if (shifted > SAT_MAX)
                clamped = {1'b0, {(W-1){1'b1}}};
            else if (shifted < SAT_MIN)
                clamped = {1'b1, {(W-1){1'b0}}};
            else
                clamped = shifted[W-1:0];
`ifdef FC_RELU_EN
            if (clamped[W-1])
                clamped = '0;
`endif
        end

        assign result[gi] = clamped;
    end

    // Staging value including the group being written this cycle, so the final
    // copy to the output sees every neuron.
    always_comb begin
        stage_next = stage_reg;
        for (int l = 0; l < LANES; l++)
            stage_next[(int'(g_reg) * LANES + l) * W +: W] = result[l];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            g_reg     <= '0;
            j_reg     <= '0;
            in_reg    <= '0;
            w_reg     <= '0;
            b_reg     <= '0;
            stage_reg <= '0;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int l = 0; l < LANES; l++)
                acc_reg[l] <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        in_reg   <= in_vector_flat;
                        w_reg    <= weights_flat;
                        b_reg    <= biases_flat;
                        g_reg    <= '0;
                        j_reg    <= '0;
                        busy_reg <= 1'b1;
                        state_reg <= MAC;
                        for (int l = 0; l < LANES; l++)
                            acc_reg[l] <= ACC_WIDTH'(signed'(biases_flat[l * W +: W]));
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++)
                        acc_reg[l] <= acc_reg[l] + prod_ext[l];
                    if (j_reg == J_LAST) begin
                        j_reg     <= '0;
                        state_reg <= WRITE;
                    end else begin
                        j_reg <= j_reg + J_W'(1);
                    end
                end
                WRITE: begin
                    stage_reg <= stage_next;
                    if (g_reg == G_LAST) begin
                        out_reg   <= stage_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        g_reg     <= g_next;
                        j_reg     <= '0;
                        state_reg <= MAC;
                        for (int l = 0; l < LANES; l++)
                            acc_reg[l] <= next_bias[l];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_vector_flat = out_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_fc_layer_lanes.sv
// Bench for fc_layer_lanes: transaction-level model checked every cycle plus directed literal cases.
// Expected values follow FC_RELU_EN when the bundle is built with it.
module tb_fc_layer_lanes;
    localparam int IN  = 16;
    localparam int OUT = 8;
    localparam int W   = 8;
    localparam int LAT = (OUT / 2) * (IN + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [W*IN-1:0]       in_vec;
    logic [W*OUT*IN-1:0]   w_vec;
    logic [W*OUT-1:0]      b_vec;
    logic [W*OUT-1:0]      out, out_l1, out_l8, out_fs;
    logic                  busy, busy_l1, busy_l8, busy_fs;
    logic                  done, done_l1, done_l8, done_fs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_layer_lanes #(.IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(2), .W(W), .ACC_WIDTH(24), .FRAC_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec), .weights_flat(w_vec),
        .biases_flat(b_vec), .out_vector_flat(out), .busy(busy), .done(done));
    fc_layer_lanes #(.IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(1), .W(W), .ACC_WIDTH(24), .FRAC_SHIFT(0)) dut_l1 (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec), .weights_flat(w_vec),
        .biases_flat(b_vec), .out_vector_flat(out_l1), .busy(busy_l1), .done(done_l1));
    fc_layer_lanes #(.IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(8), .W(W), .ACC_WIDTH(24), .FRAC_SHIFT(0)) dut_l8 (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec), .weights_flat(w_vec),
        .biases_flat(b_vec), .out_vector_flat(out_l8), .busy(busy_l8), .done(done_l8));
    fc_layer_lanes #(.IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(2), .W(W), .ACC_WIDTH(24), .FRAC_SHIFT(2)) dut_fs (
        .clk(clk), .reset(reset), .start(start), .in_vector_flat(in_vec), .weights_flat(w_vec),
        .biases_flat(b_vec), .out_vector_flat(out_fs), .busy(busy_fs), .done(done_fs));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [W*OUT-1:0] act, input logic [W*OUT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_vals(input string name, input logic [W*OUT-1:0] v, input int e [OUT]);
        logic signed [W-1:0] t;
        for (int i = 0; i < OUT; i++) begin
            t = v[i*W +: W];
            chk($sformatf("%s[%0d]", name, i), t, e[i]);
        end
        $display("%s: checked %0d neurons", name, OUT);
    endtask

    // Reference: plain integer dot product, floor shift, clamp, optional ReLU.
    function automatic logic [W*OUT-1:0] model_fc(input logic [W*IN-1:0] iv, input logic [W*OUT*IN-1:0] wv,
                                                  input logic [W*OUT-1:0] bv, input int shift);
        logic [W*OUT-1:0]    r;
        logic signed [W-1:0] a, b;
        longint              s;
        r = '0;
        for (int i = 0; i < OUT; i++) begin
            b = bv[i*W +: W];
            s = longint'(b);
            for (int j = 0; j < IN; j++) begin
                a = iv[j*W +: W];
                b = wv[(i*IN + j)*W +: W];
                s = s + longint'(a) * longint'(b);
            end
            s = s >>> shift;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
`ifdef FC_RELU_EN
            if (s < 0) s = 0;
`endif
            r[i*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    // Transaction model of the default instance: busy for LAT edges after an accepted start.
    logic             m_busy, m_done;
    logic [W*OUT-1:0] m_out, m_pending;
    int               m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_out <= '0; m_pending <= '0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_out <= m_pending;
                end
                m_cnt <= m_cnt - 1;
            end else if (start) begin
                m_busy    <= 1'b1;
                m_cnt     <= LAT;
                m_pending <= model_fc(in_vec, w_vec, b_vec, 0);
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", busy, m_busy);
        chk("cmp_done", done, m_done);
        chk_vec("cmp_out", out, m_out);
    end

    task automatic set_stim1();
        int pat [4] = '{1, 1, -1, 0};
        int bv;
        for (int j = 0; j < IN; j++) in_vec[j*W +: W] = W'(j + 1);
        for (int i = 0; i < OUT; i++) begin
            for (int j = 0; j < IN; j++) w_vec[(i*IN + j)*W +: W] = W'(pat[j % 4]);
            bv = -36 + 4*i;
            b_vec[i*W +: W] = W'(bv);
        end
    endtask

    task automatic set_sat(input int wv);
        for (int j = 0; j < IN; j++) in_vec[j*W +: W] = 8'd127;
        for (int k = 0; k < OUT*IN; k++) w_vec[k*W +: W] = W'(wv);
        b_vec = '0;
    endtask

    // Called right after a falling edge; returns right after the falling edge that sees done.
    task automatic run(input bit disturb, output int lat);
        lat = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 300 && lat < 0; n++) begin
            if (disturb && n == 1) begin
                for (int k = 0; k < OUT*IN*W/32; k++) w_vec[k*32 +: 32] = $urandom;
                in_vec = ~in_vec;
                b_vec  = ~b_vec;
            end
            if (disturb) start = (n == 10);
            @(negedge clk);
            if (done) lat = n;
        end
        start = 1'b0;
    endtask

    int exp1 [OUT], exp_fs [OUT], exp_pos [OUT], exp_neg [OUT];
    int lat, lat_m, lat_1, lat_8, lat_f;

    initial begin
`ifdef FC_RELU_EN
        exp1   = '{0, 0, 0, 0, 4, 8, 12, 16};
        exp_fs = '{0, 0, 0, 0, 1, 2, 3, 4};
        exp_neg = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp1   = '{-12, -8, -4, 0, 4, 8, 12, 16};
        exp_fs = '{-3, -2, -1, 0, 1, 2, 3, 4};
        exp_neg = '{-128, -128, -128, -128, -128, -128, -128, -128};
`endif
        exp_pos = '{127, 127, 127, 127, 127, 127, 127, 127};

        start = 1'b0; in_vec = '0; w_vec = '0; b_vec = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk_vec("reset_out", out, '0);
        reset = 1'b0;
        @(negedge clk);

        // All four instances accept on the same edge; record each one's done latency.
        set_stim1();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_m = -1; lat_1 = -1; lat_8 = -1; lat_f = -1;
        for (int n = 1; n <= 160; n++) begin
            if (n < LAT) chk("t1_busy_held", busy, 1);
            @(negedge clk);
            if (done && lat_m < 0) lat_m = n;
            if (done_l1 && lat_1 < 0) lat_1 = n;
            if (done_l8 && lat_8 < 0) lat_8 = n;
            if (done_fs && lat_f < 0) lat_f = n;
        end
        chk("t1_latency_l2", lat_m, 68);
        chk("t1_latency_l1", lat_1, 136);
        chk("t1_latency_l8", lat_8, 17);
        chk("t1_latency_fs", lat_f, 68);
        chk_vals("t1_out_l2", out, exp1);
        chk_vals("t1_model", m_out, exp1);
        chk_vals("t1_out_l1", out_l1, exp1);
        chk_vals("t1_out_l8", out_l8, exp1);
        chk_vals("t1_out_fs", out_fs, exp_fs);

        set_sat(127);
        run(1'b0, lat);
        chk("sat_pos_latency", lat, 68);
        chk_vals("sat_pos", out, exp_pos);

        set_sat(-128);
        run(1'b0, lat);
        chk("sat_neg_latency", lat, 68);
        chk_vals("sat_neg", out, exp_neg);

        // Stray start at cycle 10 and operand changes after accept must not matter.
        set_stim1();
        run(1'b1, lat);
        chk("disturb_latency", lat, 68);
        chk_vals("disturb", out, exp1);

        // Back-to-back: start raised in the done cycle.
        set_stim1();
        run(1'b0, lat);
        chk("b2b_first_latency", lat, 68);
        chk("b2b_done_high", done, 1);
        chk_vals("b2b_first", out, exp1);
        set_sat(127);
        run(1'b0, lat);
        chk("b2b_second_latency", lat, 68);
        chk_vals("b2b_second", out, exp_pos);

        // Asynchronous reset partway through MAC.
        set_stim1();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk_vec("rst_mid_out", out, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        run(1'b0, lat);
        chk("rst_rerun_latency", lat, 68);
        chk_vals("rst_rerun", out, exp1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
